// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family.
//   GRAY_DEF_WIDTH   : default counter width
//   GRAY_DEF_MODULUS : default number of states
//   bin2gray()       : binary -> Gray (up to 32 bits, caller truncates)
//   gray2bin()       : Gray -> binary (up to 32 bits, caller truncates)
package gray_pkg;

    localparam int GRAY_DEF_WIDTH   = 3;
    localparam int GRAY_DEF_MODULUS = 7;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_counter_param_bin2gray.sv
// Purely combinational binary-to-Gray converter, shared with the Gray
// pointer blocks.
// Ports:
//   bin  [WIDTH-1:0] in  : binary value
//   gray [WIDTH-1:0] out : Gray-coded value
module bin2gray #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_param.sv
// Modulo-MODULUS up/down counter with registered Gray and binary outputs,
// synchronous parallel load (clamped to MODULUS-1) and a terminal-count flag.
// Build option: define GRAY_CNT_SATURATE_EN to saturate at the range limits
// instead of wrapping around.
// Ports:
//   clk      in  : rising-edge clock
//   rst      in  : synchronous active-low reset
//   enable   in  : advance one state per cycle
//   up_dn    in  : 1 = count up, 0 = count down
//   load     in  : synchronous load strobe (beats enable)
//   load_val in  : binary value to load
//   out      out : Gray-coded count (registered)
//   out_bin  out : binary count (registered, same edge as out)
//   tc       out : enabled edge would wrap (or sits at a limit when saturating)
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int WIDTH   = GRAY_DEF_WIDTH,
    parameter int MODULUS = GRAY_DEF_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_bin,
    output logic             tc
);

    // MODULUS may equal 2**WIDTH, so the clamp compare needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             at_limit;

    // Limit in the current direction: top when counting up, zero when down.
    assign at_limit = up_dn ? (cnt == MAX_VAL) : (cnt == '0);
    assign tc       = enable & ~load & at_limit;

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;
        end else if (enable) begin
`ifdef GRAY_CNT_SATURATE_EN
            if (!at_limit) begin
                cnt_nxt = up_dn ? cnt + 1'b1 : cnt - 1'b1;
            end
`else
            if (up_dn) begin
                cnt_nxt = at_limit ? '0 : cnt + 1'b1;
            end else begin
                cnt_nxt = at_limit ? MAX_VAL : cnt - 1'b1;
            end
`endif
        end
    end

    // Gray is formed from the next binary state so out is a clean register,
    // not logic after the counter.
    bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
        .bin  (cnt_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            out <= '0;
        end else begin
            cnt <= cnt_nxt;
            out <= gray_nxt;
        end
    end

    // The binary state register doubles as the binary output.
    assign out_bin = cnt;

endmodule
